// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
package hazard_pkg;

   // Operand source select for the E-stage ALU inputs
   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   // Multiply/divide unit occupancy state
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdu_state_t;

endpackage : hazard_pkg

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
interface hazard_ctrl_if #(
   parameter int unsigned REGW = 5,
   parameter int unsigned CNTW = 16
);
   // Source/destination register addresses
   logic [REGW-1:0] rsD;
   logic [REGW-1:0] rtD;
   logic [REGW-1:0] rsE;
   logic [REGW-1:0] rtE;
   logic [REGW-1:0] writeregE;
   logic [REGW-1:0] writeregM;
   logic [REGW-1:0] writeregW;

   // Pipeline control status
   logic            regwriteE;
   logic            regwriteM;
   logic            regwriteW;
   logic            memtoregE;
   logic            memtoregM;
   logic            branchD;
   logic            mdustartE;
   logic            mduuseD;
   logic            dmemreqM;
   logic            dmemreadyM;

   // Controller decisions
   logic            forwardaD;
   logic            forwardbD;
   logic [1:0]      forwardaE;
   logic [1:0]      forwardbE;
   logic            stallF;
   logic            stallD;
   logic            stallE;
   logic            stallM;
   logic            flushE;
   logic            flushW;
   logic            mdubusy;
   logic [CNTW-1:0] stallcount;

   // Pipeline side
   modport master (
      output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
      output regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
      output branchD, mdustartE, mduuseD, dmemreqM, dmemreadyM,
      input  forwardaD, forwardbD, forwardaE, forwardbE,
      input  stallF, stallD, stallE, stallM, flushE, flushW,
      input  mdubusy, stallcount
   );

   // Hazard controller side
   modport slave (
      input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
      input  regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
      input  branchD, mdustartE, mduuseD, dmemreqM, dmemreadyM,
      output forwardaD, forwardbD, forwardaE, forwardbE,
      output stallF, stallD, stallE, stallM, flushE, flushW,
      output mdubusy, stallcount
   );

endinterface : hazard_ctrl_if

// File: rtl/hazard_ctrl_mdu_tracker.sv
// Tracks an in-flight multi-cycle multiply/divide and reports busy.
module mdu_tracker
   import hazard_pkg::*;
#(
   parameter int unsigned MDU_LAT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_start,
   input  logic i_stall_e,
   output logic o_busy
);

   localparam int unsigned   CW   = $clog2(MDU_LAT);
   localparam logic [CW-1:0] LOAD = CW'(MDU_LAT - 1);

   mdu_state_t    r_state;
   mdu_state_t    w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;

   // State and down-counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state: issue only when E advances; count runs regardless of memory stalls
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (i_start && !i_stall_e) begin
               w_state_nxt = BUSY;
               w_cnt_nxt   = LOAD;
            end
         end
         BUSY: begin
            w_cnt_nxt = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_busy = (r_state == BUSY);

endmodule : mdu_tracker

// File: rtl/hazard_ctrl.sv
// Hazard detection, forwarding select, stall/flush resolution and stall counter
// for the 5-stage MIPS pipeline.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REGW    = 5,
   parameter int unsigned MDU_LAT = 4,
   parameter int unsigned CNTW    = 16
) (
   input  logic         clk,
   input  logic         reset,
   hazard_ctrl_if.slave hif
);

   logic            w_lwstall;
   logic            w_brstall;
   logic            w_memstall;
   logic            w_mdustall;
   logic            w_mdubusy;
   logic            w_stall_f;
   logic            w_stall_d;
   logic            w_stall_e;
   logic            w_stall_m;
   logic            w_flush_e;
   logic            w_flush_w;
   fwd_sel_t        w_fwd_ae;
   fwd_sel_t        w_fwd_be;
   logic [CNTW-1:0] r_stallcount;

   // MDU occupancy tracker
   mdu_tracker #(
      .MDU_LAT (MDU_LAT)
   ) u_mdu_tracker (
      .clk       (clk),
      .reset     (reset),
      .i_start   (hif.mdustartE),
      .i_stall_e (w_stall_e),
      .o_busy    (w_mdubusy)
   );

   // E-stage forwarding: M result wins over W, register 0 never forwards
   always_comb begin
      w_fwd_ae = FWD_RF;
      w_fwd_be = FWD_RF;
      if (hif.rsE != '0 && hif.regwriteM && hif.rsE == hif.writeregM) begin
         w_fwd_ae = FWD_M;
      end else if (hif.rsE != '0 && hif.regwriteW && hif.rsE == hif.writeregW) begin
         w_fwd_ae = FWD_W;
      end
      if (hif.rtE != '0 && hif.regwriteM && hif.rtE == hif.writeregM) begin
         w_fwd_be = FWD_M;
      end else if (hif.rtE != '0 && hif.regwriteW && hif.rtE == hif.writeregW) begin
         w_fwd_be = FWD_W;
      end
   end

   assign hif.forwardaE = w_fwd_ae;
   assign hif.forwardbE = w_fwd_be;
   assign hif.forwardaD = (hif.rsD != '0) && hif.regwriteM && (hif.rsD == hif.writeregM);
   assign hif.forwardbD = (hif.rtD != '0) && hif.regwriteM && (hif.rtD == hif.writeregM);

   // Raw hazard terms
   always_comb begin
      w_lwstall  = hif.memtoregE && (hif.rtE != '0) &&
                   ((hif.rtE == hif.rsD) || (hif.rtE == hif.rtD));
      w_brstall  = hif.branchD &&
                   ((hif.regwriteE && (hif.writeregE != '0) &&
                     ((hif.writeregE == hif.rsD) || (hif.writeregE == hif.rtD))) ||
                    (hif.memtoregM && (hif.writeregM != '0) &&
                     ((hif.writeregM == hif.rsD) || (hif.writeregM == hif.rtD))));
      w_memstall = hif.dmemreqM && !hif.dmemreadyM;
      w_mdustall = hif.mduuseD && w_mdubusy;
   end

   // Stall/flush priority: reset, then memory wait freezes everything, then D-stage hazards
   always_comb begin
      w_stall_f = 1'b0;
      w_stall_d = 1'b0;
      w_stall_e = 1'b0;
      w_stall_m = 1'b0;
      w_flush_e = 1'b0;
      w_flush_w = 1'b0;
      if (reset) begin
         w_flush_e = 1'b1;
         w_flush_w = 1'b1;
      end else if (w_memstall) begin
         w_stall_f = 1'b1;
         w_stall_d = 1'b1;
         w_stall_e = 1'b1;
         w_stall_m = 1'b1;
         w_flush_w = 1'b1;
      end else if (w_lwstall || w_brstall || w_mdustall) begin
         w_stall_f = 1'b1;
         w_stall_d = 1'b1;
         w_flush_e = 1'b1;
      end
   end

   assign hif.stallF  = w_stall_f;
   assign hif.stallD  = w_stall_d;
   assign hif.stallE  = w_stall_e;
   assign hif.stallM  = w_stall_m;
   assign hif.flushE  = w_flush_e;
   assign hif.flushW  = w_flush_w;
   assign hif.mdubusy = w_mdubusy;

   // Saturating count of fetch-stall cycles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stallcount <= '0;
      end else if (w_stall_f && (r_stallcount != '1)) begin
         r_stallcount <= r_stallcount + CNTW'(1);
      end
   end

   assign hif.stallcount = r_stallcount;

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (MDU_LAT=4, narrow stall counter).
module tb_hazard_ctrl;

   localparam int unsigned REGW    = 5;
   localparam int unsigned MDU_LAT = 4;
   localparam int unsigned CNTW    = 4;

   logic clk;
   logic reset;
   int   n_total;
   int   n_bad;

   hazard_ctrl_if #(.REGW(REGW), .CNTW(CNTW)) hif ();

   hazard_ctrl #(
      .REGW    (REGW),
      .MDU_LAT (MDU_LAT),
      .CNTW    (CNTW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hif   (hif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issuing into a busy MDU is a pipeline protocol violation
   always @(posedge clk) begin
      if (!reset) begin
         assert (!(hif.mdustartE && hif.mdubusy && !hif.stallE))
            else $error("protocol: mdustartE while mdubusy");
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clr();
      hif.rsD = '0; hif.rtD = '0; hif.rsE = '0; hif.rtE = '0;
      hif.writeregE = '0; hif.writeregM = '0; hif.writeregW = '0;
      hif.regwriteE = 1'b0; hif.regwriteM = 1'b0; hif.regwriteW = 1'b0;
      hif.memtoregE = 1'b0; hif.memtoregM = 1'b0; hif.branchD = 1'b0;
      hif.mdustartE = 1'b0; hif.mduuseD = 1'b0;
      hif.dmemreqM = 1'b0; hif.dmemreadyM = 1'b1;
   endtask

   // Move to the next cycle's drive point with quiet inputs
   task automatic nxt();
      @(negedge clk);
      clr();
   endtask

   // Check the six stall/flush outputs in one go: {F,D,E,M,flushE,flushW}
   task automatic chk_sf(input string tag, input logic [5:0] exp);
      chk(tag, 32'({hif.stallF, hif.stallD, hif.stallE, hif.stallM, hif.flushE, hif.flushW}),
          32'(exp));
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      reset   = 1'b1;
      clr();
      hif.dmemreqM = 1'b1; hif.dmemreadyM = 1'b0;
      hif.memtoregE = 1'b1; hif.rtE = 5'd5; hif.rsD = 5'd5;
      #3;
      chk_sf("reset_sf", 6'b0000_11);
      chk("reset_busy", 32'(hif.mdubusy), 32'd0);
      chk("reset_cnt", 32'(hif.stallcount), 32'd0);

      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      clr();
      #1;
      chk_sf("idle_sf", 6'b0000_00);

      // Forwarding priority
      nxt();
      hif.rsE = 5'd3; hif.writeregM = 5'd3; hif.regwriteM = 1'b1;
      hif.writeregW = 5'd3; hif.regwriteW = 1'b1;
      #1 chk("fwdaE_M", 32'(hif.forwardaE), 32'd2);
      hif.regwriteM = 1'b0;
      #1 chk("fwdaE_W", 32'(hif.forwardaE), 32'd1);
      hif.regwriteM = 1'b1; hif.rsE = 5'd0; hif.writeregM = 5'd0; hif.writeregW = 5'd0;
      #1 chk("fwdaE_r0", 32'(hif.forwardaE), 32'd0);
      nxt();
      hif.rtE = 5'd9; hif.writeregW = 5'd9; hif.regwriteW = 1'b1;
      hif.writeregM = 5'd8; hif.regwriteM = 1'b1;
      #1 chk("fwdbE_W", 32'(hif.forwardbE), 32'd1);

      // Load-use: one stall cycle, then none; rtE=0 never stalls
      nxt();
      hif.memtoregE = 1'b1; hif.rtE = 5'd5; hif.rsD = 5'd5;
      #1 chk_sf("lw_sf", 6'b1100_10);
      nxt();
      #1 chk_sf("lw_release", 6'b0000_00);
      chk("lw_cnt", 32'(hif.stallcount), 32'd1);
      hif.memtoregE = 1'b1; hif.rtE = 5'd0; hif.rsD = 5'd0;
      #1 chk("lw_r0", 32'(hif.stallF), 32'd0);

      // Branch stalls and D-stage forwarding
      nxt();
      hif.branchD = 1'b1; hif.rsD = 5'd7; hif.regwriteE = 1'b1; hif.writeregE = 5'd7;
      #1 chk_sf("br_e_sf", 6'b1100_10);
      nxt();
      hif.branchD = 1'b1; hif.rsD = 5'd7; hif.writeregM = 5'd7; hif.regwriteM = 1'b1;
      #1 chk("br_m_nostall", 32'(hif.stallF), 32'd0);
      chk("br_fwdaD", 32'(hif.forwardaD), 32'd1);
      chk("br_fwdbD", 32'(hif.forwardbD), 32'd0);
      chk("br_cnt", 32'(hif.stallcount), 32'd2);
      hif.memtoregM = 1'b1;
      #1 chk("br_load_stall", 32'(hif.stallF), 32'd1);
      nxt();
      hif.branchD = 1'b1; hif.rsD = 5'd0; hif.regwriteE = 1'b1; hif.writeregE = 5'd0;
      #1 chk("br_r0", 32'(hif.stallF), 32'd0);
      chk("br_cnt2", 32'(hif.stallcount), 32'd3);

      // MDU: restart counter, issue at cycle 0 with mduuseD held
      nxt();
      reset = 1'b1;
      #1 chk("rst_cnt", 32'(hif.stallcount), 32'd0);
      nxt();
      reset = 1'b0;
      hif.mdustartE = 1'b1; hif.mduuseD = 1'b1;
      #1 chk("mdu_c0_busy", 32'(hif.mdubusy), 32'd0);
      chk("mdu_c0_stall", 32'(hif.stallF), 32'd0);
      for (int c = 1; c <= 3; c++) begin
         nxt();
         hif.mduuseD = 1'b1;
         #1 chk($sformatf("mdu_c%0d_busy", c), 32'(hif.mdubusy), 32'd1);
         chk_sf($sformatf("mdu_c%0d_sf", c), 6'b1100_10);
      end
      nxt();
      hif.mduuseD = 1'b1;
      #1 chk("mdu_c4_busy", 32'(hif.mdubusy), 32'd0);
      chk("mdu_c4_stall", 32'(hif.stallF), 32'd0);
      chk("mdu_cnt", 32'(hif.stallcount), 32'd3);

      // Memory wait masks load-use, which appears once memory is ready
      for (int c = 0; c < 2; c++) begin
         nxt();
         hif.dmemreqM = 1'b1; hif.dmemreadyM = 1'b0;
         hif.memtoregE = 1'b1; hif.rtE = 5'd5; hif.rsD = 5'd5;
         #1 chk_sf($sformatf("mem_wait%0d_sf", c), 6'b1111_01);
      end
      nxt();
      hif.dmemreqM = 1'b1; hif.dmemreadyM = 1'b1;
      hif.memtoregE = 1'b1; hif.rtE = 5'd5; hif.rsD = 5'd5;
      #1 chk_sf("mem_ready_lw", 6'b1100_10);

      // Issue blocked while E is frozen by memory wait
      nxt();
      hif.mdustartE = 1'b1; hif.dmemreqM = 1'b1; hif.dmemreadyM = 1'b0;
      nxt();
      #1 chk("mdu_blocked", 32'(hif.mdubusy), 32'd0);
      chk("mem_cnt", 32'(hif.stallcount), 32'd7);

      // Reset during BUSY aborts at once
      hif.mdustartE = 1'b1;
      nxt();
      hif.mduuseD = 1'b1;
      #1 chk("abort_busy_pre", 32'(hif.mdubusy), 32'd1);
      reset = 1'b1;
      #1 chk("abort_busy", 32'(hif.mdubusy), 32'd0);
      chk("abort_cnt", 32'(hif.stallcount), 32'd0);
      chk_sf("abort_sf", 6'b0000_11);
      nxt();
      reset = 1'b0;
      hif.mduuseD = 1'b1;
      #1 chk("abort_nostall", 32'(hif.stallF), 32'd0);

      // Counter saturation (4-bit counter, 20 stall cycles)
      for (int c = 0; c < 20; c++) begin
         nxt();
         hif.dmemreqM = 1'b1; hif.dmemreadyM = 1'b0;
      end
      nxt();
      #1 chk("sat_cnt", 32'(hif.stallcount), 32'd15);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_hazard_ctrl
